// File: rtl/mac_t_gmii.sv
// GMII transmit MAC: pops a frame descriptor, then streams preamble, SFD, payload,
// zero pad up to MIN_FRAME, CRC-32 FCS and an inter-frame gap onto registered GMII.
module mac_t_gmii #(
  parameter int IFG_BYTES = 12,
  parameter int MIN_FRAME = 60
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tx_enable,
  output logic        ptr_fifo_rd,
  input  logic [15:0] ptr_fifo_dout,
  input  logic        ptr_fifo_empty,
  output logic        data_fifo_rd,
  input  logic [7:0]  data_fifo_dout,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        frame_sent
);

  typedef enum logic [2:0] {IDLE, LEN, PRE, SFD, DATA, PAD, FCS, IFG} state_t;

  localparam logic [11:0] MIN_LEN  = 12'(MIN_FRAME);
  localparam logic [11:0] IFG_LAST = 12'(IFG_BYTES - 1);

  state_t      state_reg, state_next;
  logic [11:0] cnt_reg, cnt_next;
  logic [11:0] len_reg, len_next;
  logic [11:0] rd_left_reg, rd_left_next;
  logic [31:0] crc_reg, crc_next;
  logic        run_reg;
  logic [7:0]  txd_reg, txd_next;
  logic        tx_en_reg, tx_en_next;
  logic        ptr_rd_reg, ptr_rd_next;
  logic        data_rd_reg, data_rd_next;
  logic        sent_reg, sent_next;
  logic [31:0] fcs_word, fcs_shift;
  logic        unused_bits;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++)
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  assign fcs_word    = ~crc_reg;
  assign fcs_shift   = fcs_word >> {cnt_reg[1:0] + 2'd1, 3'b000};
  assign unused_bits = ^ptr_fifo_dout[15:12];

  // Registered outputs describe the state being entered, so the wire shows the current phase.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    len_next     = len_reg;
    crc_next     = crc_reg;
    txd_next     = 8'h00;
    tx_en_next   = 1'b0;
    ptr_rd_next  = 1'b0;
    sent_next    = 1'b0;
    data_rd_next = 1'b0;
    rd_left_next = rd_left_reg;
    if (rd_left_reg != 12'd0) begin
      data_rd_next = 1'b1;
      rd_left_next = rd_left_reg - 12'd1;
    end
    case (state_reg)
      IDLE: if (run_reg && tx_enable && !ptr_fifo_empty) begin
        state_next  = LEN;
        ptr_rd_next = 1'b1;
      end
      LEN: begin
        len_next = ptr_fifo_dout[11:0];
        crc_next = 32'hFFFFFFFF;
        cnt_next = 12'd0;
        if (ptr_fifo_dout[11:0] == 12'd0) begin
          state_next = IDLE;
        end else begin
          state_next = PRE;
          tx_en_next = 1'b1;
          txd_next   = 8'h55;
        end
      end
      PRE: begin
        tx_en_next = 1'b1;
        // Reads start one cycle ahead so the FIFO latency is hidden behind SFD.
        if (cnt_reg == 12'd5) begin
          data_rd_next = 1'b1;
          rd_left_next = len_reg - 12'd1;
        end
        if (cnt_reg == 12'd6) begin
          state_next = SFD;
          txd_next   = 8'hD5;
          cnt_next   = 12'd0;
        end else begin
          txd_next = 8'h55;
          cnt_next = cnt_reg + 12'd1;
        end
      end
      SFD: begin
        state_next = DATA;
        tx_en_next = 1'b1;
        txd_next   = data_fifo_dout;
        crc_next   = crc_byte(crc_reg, data_fifo_dout);
        cnt_next   = 12'd0;
      end
      DATA: begin
        tx_en_next = 1'b1;
        if (cnt_reg == len_reg - 12'd1) begin
          cnt_next = 12'd0;
          if (len_reg < MIN_LEN) begin
            state_next = PAD;
            crc_next   = crc_byte(crc_reg, 8'h00);
          end else begin
            state_next = FCS;
            txd_next   = fcs_word[7:0];
          end
        end else begin
          cnt_next = cnt_reg + 12'd1;
          txd_next = data_fifo_dout;
          crc_next = crc_byte(crc_reg, data_fifo_dout);
        end
      end
      PAD: begin
        tx_en_next = 1'b1;
        if (cnt_reg == MIN_LEN - len_reg - 12'd1) begin
          state_next = FCS;
          txd_next   = fcs_word[7:0];
          cnt_next   = 12'd0;
        end else begin
          cnt_next = cnt_reg + 12'd1;
          crc_next = crc_byte(crc_reg, 8'h00);
        end
      end
      FCS: begin
        if (cnt_reg == 12'd3) begin
          state_next = IFG;
          cnt_next   = 12'd0;
          sent_next  = 1'b1;
        end else begin
          tx_en_next = 1'b1;
          txd_next   = fcs_shift[7:0];
          cnt_next   = cnt_reg + 12'd1;
        end
      end
      IFG: begin
        if (cnt_reg == IFG_LAST) begin
          state_next = IDLE;
          cnt_next   = 12'd0;
        end else begin
          cnt_next = cnt_reg + 12'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      cnt_reg     <= 12'd0;
      len_reg     <= 12'd0;
      rd_left_reg <= 12'd0;
      crc_reg     <= 32'hFFFFFFFF;
      run_reg     <= 1'b0;
      txd_reg     <= 8'h00;
      tx_en_reg   <= 1'b0;
      ptr_rd_reg  <= 1'b0;
      data_rd_reg <= 1'b0;
      sent_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      len_reg     <= len_next;
      rd_left_reg <= rd_left_next;
      crc_reg     <= crc_next;
      run_reg     <= 1'b1;
      txd_reg     <= txd_next;
      tx_en_reg   <= tx_en_next;
      ptr_rd_reg  <= ptr_rd_next;
      data_rd_reg <= data_rd_next;
      sent_reg    <= sent_next;
    end
  end

  assign gmii_txd     = txd_reg;
  assign gmii_tx_en   = tx_en_reg;
  assign gmii_tx_er   = 1'b0;
  assign ptr_fifo_rd  = ptr_rd_reg;
  assign data_fifo_rd = data_rd_reg;
  assign frame_sent   = sent_reg;

endmodule

// File: tb/tb_mac_t_gmii.sv
// Bench for mac_t_gmii: FIFO models feed frames, a monitor captures the GMII stream and
// every frame is compared against a byte-level reference built from the framing rules.
module tb_mac_t_gmii;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        tx_enable = 1'b1;
  logic        ptr_fifo_rd;
  logic [15:0] ptr_fifo_dout = 16'h0;
  logic        ptr_fifo_empty = 1'b1;
  logic        data_fifo_rd;
  logic [7:0]  data_fifo_dout = 8'h00;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic        frame_sent;

  mac_t_gmii #(.IFG_BYTES(12), .MIN_FRAME(60)) dut (
    .clk(clk), .rstn(rstn), .tx_enable(tx_enable),
    .ptr_fifo_rd(ptr_fifo_rd), .ptr_fifo_dout(ptr_fifo_dout), .ptr_fifo_empty(ptr_fifo_empty),
    .data_fifo_rd(data_fifo_rd), .data_fifo_dout(data_fifo_dout),
    .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
    .frame_sent(frame_sent)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] ptr_q[$];
  logic [7:0]  data_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  int          rise_q[$], fall_q[$], rdrise_q[$], sent_q[$];
  int          n_rd = 0, n_ptr = 0, n_overlap = 0, n_idle_bad = 0;
  logic        prev_en = 1'b0, prev_rd = 1'b0;
  logic [31:0] crc_tab[256];
  logic [31:0] last_fcs;
  int          rx0, rise0, fall0, rdr0, sent0, nrd0, nptr0, ov0, ib0;

  // Descriptor FIFO is show-ahead; byte FIFO has one cycle of read latency.
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (ptr_fifo_rd && ptr_q.size() != 0) ptr_q.delete(0);
    if (data_fifo_rd) data_fifo_dout <= (data_q.size() != 0) ? data_q.pop_front() : 8'h00;
  end
  always @(negedge clk) begin
    ptr_fifo_empty = (ptr_q.size() == 0);
    ptr_fifo_dout  = (ptr_q.size() != 0) ? ptr_q[0] : 16'h0;
  end

  always @(negedge clk) begin
    if (gmii_tx_en) rx_q.push_back(gmii_txd);
    if (gmii_tx_en && !prev_en) rise_q.push_back(cyc);
    if (!gmii_tx_en && prev_en) fall_q.push_back(cyc);
    if (data_fifo_rd) n_rd++;
    if (data_fifo_rd && !prev_rd) rdrise_q.push_back(cyc);
    if (ptr_fifo_rd) n_ptr++;
    if (frame_sent) sent_q.push_back(cyc);
    if (ptr_fifo_rd && data_fifo_rd) n_overlap++;
    if (!gmii_tx_en && gmii_txd != 8'h00) n_idle_bad++;
    prev_en = gmii_tx_en;
    prev_rd = data_fifo_rd;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference frame: preamble, SFD, payload, zero pad to 60 bytes, complemented CRC LSB first.
  task automatic queue_frame(input int len);
    logic [7:0]  b;
    logic [31:0] c;
    int          padded;
    c = 32'hFFFFFFFF;
    if (len > 0) begin
      for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      padded = (len < 60) ? 60 : len;
      for (int i = 0; i < padded; i++) begin
        b = 8'h00;
        if (i < len) begin
          b = (len == 14) ? 8'(i + 1) : 8'($urandom);
          data_q.push_back(b);
        end
        exp_q.push_back(b);
        c = crc_tab[(c ^ {24'h0, b}) & 32'hFF] ^ (c >> 8);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
      last_fcs = c;
    end
    ptr_q.push_back({4'($urandom), 12'(len)});
  endtask

  task automatic snap();
    rx0 = rx_q.size(); rise0 = rise_q.size(); fall0 = fall_q.size(); rdr0 = rdrise_q.size();
    sent0 = sent_q.size(); nrd0 = n_rd; nptr0 = n_ptr; ov0 = n_overlap; ib0 = n_idle_bad;
    exp_q.delete();
  endtask

  task automatic wait_done(input int nsent, input int budget);
    int n = 0;
    while (sent_q.size() - sent0 < nsent && n < budget) begin @(posedge clk); n++; end
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic verify(input string tag, input int exp_ptr, input int exp_txen,
                        input int exp_rd, input int exp_sent);
    int mism, r, f, rd1, s, e;
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (rx0 + i >= rx_q.size() || rx_q[rx0 + i] !== exp_q[i]) mism++;
    check({tag, "_bytes_wrong"}, mism, 0);
    check({tag, "_txen_cycles"}, rx_q.size() - rx0, exp_txen);
    check({tag, "_data_rd"}, n_rd - nrd0, exp_rd);
    check({tag, "_ptr_rd"}, n_ptr - nptr0, exp_ptr);
    check({tag, "_frame_sent"}, sent_q.size() - sent0, exp_sent);
    check({tag, "_rd_runs"}, rdrise_q.size() - rdr0, exp_sent);
    check({tag, "_rd_overlap"}, n_overlap - ov0, 0);
    check({tag, "_idle_txd_nonzero"}, n_idle_bad - ib0, 0);
    if (exp_sent > 0) begin
      r   = (rise_q.size()   > rise0) ? rise_q[rise0]  : -1000;
      f   = (fall_q.size()   > fall0) ? fall_q[fall0]  : -2000;
      rd1 = (rdrise_q.size() > rdr0)  ? rdrise_q[rdr0] : -3000;
      s   = (sent_q.size()   > sent0) ? sent_q[sent0]  : -4000;
      e   = rx_q.size();
      check({tag, "_rd_start_vs_preamble"}, rd1 - r, 6);
      check({tag, "_sent_vs_txen_fall"}, s - f, 0);
      if (e - 4 >= rx0)
        check({tag, "_fcs"}, {rx_q[e-1], rx_q[e-2], rx_q[e-3], rx_q[e-4]}, last_fcs);
      else
        check({tag, "_fcs_present"}, e - rx0, 4);
    end
    $display("[TB] %s: txen=%0d data_rd=%0d ptr_rd=%0d sent=%0d", tag,
             rx_q.size() - rx0, n_rd - nrd0, n_ptr - nptr0, sent_q.size() - sent0);
  endtask

  typedef struct {
    int len;
    bit drop_te;
    int exp_txen;
    int exp_rd;
    int exp_sent;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int n, len;
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[i] = c;
    end
    vecs[0] = '{14,   1'b0, 72,   14,   1};
    vecs[1] = '{100,  1'b0, 112,  100,  1};
    vecs[2] = '{60,   1'b0, 72,   60,   1};
    vecs[3] = '{59,   1'b0, 72,   59,   1};
    vecs[4] = '{61,   1'b1, 73,   61,   1};
    vecs[5] = '{1,    1'b0, 72,   1,    1};
    vecs[6] = '{0,    1'b0, 0,    0,    0};
    vecs[7] = '{4095, 1'b0, 4107, 4095, 1};

    #12;
    check("reset_outputs", {gmii_tx_en, gmii_txd, ptr_fifo_rd, data_fifo_rd, frame_sent, gmii_tx_er}, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (3) @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      snap();
      queue_frame(vecs[v].len);
      if (vecs[v].drop_te) begin
        n = 0;
        while (rise_q.size() == rise0 && n < 100) begin @(posedge clk); n++; end
        #1;
        tx_enable = 1'b0;
      end
      if (vecs[v].exp_sent > 0) wait_done(1, vecs[v].len + 200);
      else begin repeat (40) @(posedge clk); #1; end
      verify($sformatf("vec%0d_len%0d", v, vecs[v].len), 1, vecs[v].exp_txen,
             vecs[v].exp_rd, vecs[v].exp_sent);
      tx_enable = 1'b1;
    end

    for (int k = 0; k < 6; k++) begin
      len = $urandom_range(1, 300);
      snap();
      queue_frame(len);
      wait_done(1, len + 200);
      verify($sformatf("rand%0d_len%0d", k, len), 1, 12 + ((len < 60) ? 60 : len), len, 1);
    end

    // Back-to-back descriptors: gap is IFG plus the IDLE and LEN cycles.
    snap();
    queue_frame(60);
    queue_frame(64);
    wait_done(2, 600);
    verify("b2b", 2, 72 + 76, 124, 2);
    check("b2b_gap", ((rise_q.size() > rise0 + 1) ? rise_q[rise0 + 1] : -1000) -
                     ((fall_q.size() > fall0) ? fall_q[fall0] : 0), 14);

    tx_enable = 1'b0;
    snap();
    queue_frame(30);
    repeat (40) @(posedge clk); #1;
    check("disabled_no_ptr_rd", n_ptr - nptr0, 0);
    check("disabled_no_txen", rx_q.size() - rx0, 0);
    tx_enable = 1'b1;
    wait_done(1, 300);
    verify("enabled_late", 1, 72, 30, 1);

    snap();
    queue_frame(200);
    n = 0;
    while (n_rd - nrd0 < 50 && n < 300) begin @(posedge clk); n++; end
    #1;
    rstn = 1'b0;
    #1;
    check("reset_async_txen_low", gmii_tx_en, 0);
    check("reset_async_data_rd_low", data_fifo_rd, 0);
    ptr_q.delete();
    data_q.delete();
    repeat (2) @(posedge clk); #1;
    snap();
    queue_frame(30);
    repeat (2) @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    check("no_ptr_rd_first_edge", ptr_fifo_rd, 0);
    check("idle_after_reset", gmii_tx_en, 0);
    wait_done(1, 300);
    verify("after_reset", 1, 72, 30, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
